clock_time_counter: RTL

- Timekeeping stage directly downstream of the pulse generator: consumes its 1 Hz tick (o_pulse_n) and its set-rate tick (o_pulse_f or o_pulse_vf, selected upstream).
- Maintains hours, minutes and seconds as packed BCD, with a hour/minute set mode driven by debounced buttons.
- Feeds the 7-segment display driver with BCD digits, colon blink and PM flag.

---
 rtl/clock_time_counter_if.sv | 25 ++
 rtl/clock_time_counter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/clock_time_counter_if.sv
// Tick/button inputs and BCD time outputs of the clock time counter.
// The slave modport is the counter itself; the master side drives the
// ticks and set buttons and observes the time.
interface clock_time_counter_if;
  logic       i_tick_1hz;
  logic       i_tick_set;
  logic       i_set_hr;
  logic       i_set_min;
  logic [7:0] o_hours;
  logic [7:0] o_minutes;
  logic [7:0] o_seconds;
  logic       o_pm;
  logic       o_colon;
  logic       o_day_carry;

  modport slave (
    input  i_tick_1hz, i_tick_set, i_set_hr, i_set_min,
    output o_hours, o_minutes, o_seconds, o_pm, o_colon, o_day_carry
  );

  modport master (
    output i_tick_1hz, i_tick_set, i_set_hr, i_set_min,
    input  o_hours, o_minutes, o_seconds, o_pm, o_colon, o_day_carry
  );
endinterface

// File: rtl/clock_time_counter.sv
// BCD hours/minutes/seconds timekeeper with hour/minute set modes.
// The mode is decoded from the set buttons every cycle, so there is no FSM:
// RUN counts seconds on the 1 Hz tick, SET_HR/SET_MIN advance one field on
// the set tick while seconds are held at 00 and the colon is held lit.
module clock_time_counter #(
  parameter bit MODE_24H = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  clock_time_counter_if.slave   bus
);

  localparam logic [7:0] HOURS_RST = MODE_24H ? 8'h00 : 8'h12;

  logic [7:0] hours_reg,   hours_next;
  logic [7:0] minutes_reg, minutes_next;
  logic [7:0] seconds_reg, seconds_next;
  logic       pm_reg,      pm_next;
  logic       colon_reg,   colon_next;
  logic       day_carry_reg, day_carry_next;

  logic [8:0] sec_inc;   // {carry, next value}
  logic [8:0] min_inc;   // {carry, next value}
  logic [8:0] hr_inc;    // {pm after step, next value}
  logic       hour_last;
  logic       mode_set_hr;
  logic       mode_set_min;

  // Minutes/seconds step 00..59; an out-of-range value recovers to 00
  // without producing a carry.
  function automatic logic [8:0] inc_sexa(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return {1'b0, 8'h00};
    if (v == 8'h59)                     return {1'b1, 8'h00};
    if (v[3:0] == 4'd9)                 return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // One hour step in the configured format. In 12-hour mode the PM flag
  // flips only on 11->12; illegal values recover to the hour reset value.
  function automatic logic [8:0] inc_hours(input logic [7:0] v, input logic pm);
    logic legal;
    if (MODE_24H) begin
      legal = (v[7:4] <= 4'd1 && v[3:0] <= 4'd9) ||
              (v[7:4] == 4'd2 && v[3:0] <= 4'd3);
      if (!legal || v == 8'h23) return {pm, 8'h00};
      if (v[3:0] == 4'd9)       return {pm, v[7:4] + 4'd1, 4'd0};
      return {pm, v[7:4], v[3:0] + 4'd1};
    end else begin
      legal = (v[7:4] == 4'd0 && v[3:0] != 4'd0 && v[3:0] <= 4'd9) ||
              (v[7:4] == 4'd1 && v[3:0] <= 4'd2);
      if (!legal)     return {pm, 8'h12};
      if (v == 8'h12) return {pm, 8'h01};
      if (v == 8'h11) return {~pm, 8'h12};
      if (v == 8'h09) return {pm, 8'h10};
      return {pm, v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  assign sec_inc      = inc_sexa(seconds_reg);
  assign min_inc      = inc_sexa(minutes_reg);
  assign hr_inc       = inc_hours(hours_reg, pm_reg);
  assign hour_last    = MODE_24H ? (hours_reg == 8'h23) : (hours_reg == 8'h11 && pm_reg);
  assign mode_set_hr  = bus.i_set_hr;
  assign mode_set_min = !bus.i_set_hr && bus.i_set_min;

  // Next-state decode: RUN counting with cascaded carries, or a set-mode step.
  always_comb begin
    hours_next     = hours_reg;
    minutes_next   = minutes_reg;
    seconds_next   = seconds_reg;
    pm_next        = pm_reg;
    colon_next     = colon_reg;
    day_carry_next = 1'b0;
    if (mode_set_hr || mode_set_min) begin
      seconds_next = 8'h00;
      colon_next   = 1'b1;
      if (bus.i_tick_set) begin
        if (mode_set_hr) begin
          hours_next = hr_inc[7:0];
          pm_next    = hr_inc[8];
        end else begin
          minutes_next = min_inc[7:0];
        end
      end
    end else if (bus.i_tick_1hz) begin
      colon_next   = ~colon_reg;
      seconds_next = sec_inc[7:0];
      if (sec_inc[8]) begin
        minutes_next = min_inc[7:0];
        if (min_inc[8]) begin
          hours_next     = hr_inc[7:0];
          pm_next        = hr_inc[8];
          day_carry_next = hour_last;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      hours_reg     <= HOURS_RST;
      minutes_reg   <= 8'h00;
      seconds_reg   <= 8'h00;
      pm_reg        <= 1'b0;
      colon_reg     <= 1'b1;
      day_carry_reg <= 1'b0;
    end else begin
      hours_reg     <= hours_next;
      minutes_reg   <= minutes_next;
      seconds_reg   <= seconds_next;
      pm_reg        <= pm_next;
      colon_reg     <= colon_next;
      day_carry_reg <= day_carry_next;
    end
  end

  assign bus.o_hours     = hours_reg;
  assign bus.o_minutes   = minutes_reg;
  assign bus.o_seconds   = seconds_reg;
  assign bus.o_pm        = MODE_24H ? 1'b0 : pm_reg;
  assign bus.o_colon     = colon_reg;
  assign bus.o_day_carry = day_carry_reg;

endmodule
